// File: rtl/pattern_detector_pkg.sv
// Shared types and pattern helpers for the parametrised PRBS pattern detector.
package pattern_detector_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HUNT  = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [31:0] DEFAULT_PATTERN = 32'hABCDEF23;

  // Widest pattern the helper can slice: 16 words of up to 64 bits.
  localparam int unsigned MAX_PAT_BITS = 1024;

  // Word idx sits at the top of PATTERN for idx 0; the caller truncates to DATA_W.
  function automatic logic [MAX_PAT_BITS-1:0] pat_word(
    input logic [MAX_PAT_BITS-1:0] pattern,
    input int unsigned             data_w,
    input int unsigned             pat_words,
    input int unsigned             idx
  );
    return pattern >> (data_w * (pat_words - 1 - idx));
  endfunction

endpackage

// File: rtl/pd_sat_counter.sv
// Saturating up-counter with synchronous clear and count enable.
module pd_sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // NOTE: count_d gets its default before any branch so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pattern_detector_gen.sv
// Checks a valid-qualified stream against PATTERN repeated n_detec times,
// with optional sync hunt, stop-on-error or error counting, and registered status.
module pattern_detector_gen
  import pattern_detector_pkg::*;
#(
  parameter int unsigned                  DATA_W      = 8,
  parameter int unsigned                  PAT_WORDS   = 4,
  parameter logic [DATA_W*PAT_WORDS-1:0]  PATTERN     = DEFAULT_PATTERN,
  parameter int unsigned                  REP_W       = 8,
  parameter bit                           STOP_ON_ERR = 1'b1,
  parameter bit                           SYNC_HUNT   = 1'b0,
  parameter int unsigned                  HUNT_MAX    = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [REP_W-1:0]  n_detec,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              busy,
  output logic              done,
  output logic              pattern_flag,
  output logic              timeout,
  output logic [REP_W-1:0]  err_cnt,
  output logic [REP_W-1:0]  rep_cnt
);

  localparam int unsigned IDX_W = (PAT_WORDS > 1) ? $clog2(PAT_WORDS) : 1;

  logic [DATA_W-1:0] pat_words [PAT_WORDS];

  for (genvar g = 0; g < PAT_WORDS; g++) begin : g_pat
    assign pat_words[g] = DATA_W'(pat_word(MAX_PAT_BITS'(PATTERN), DATA_W, PAT_WORDS, g));
  end

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [REP_W-1:0]  n_q;
  logic              busy_q, done_q, flag_q, flag_d, timeout_q, timeout_d;
  logic [REP_W-1:0]  hunt_cnt;

  logic start_acc;
  logic in_check, in_hunt;
  logic mism, last_word, hunt_hit, hunt_miss, hunt_to;
  logic err_en, rep_en, rep_done;

  assign start_acc = start && (state_q == ST_IDLE);
  assign in_check  = in_valid && (state_q == ST_CHECK);
  assign in_hunt   = in_valid && (state_q == ST_HUNT);

  assign last_word = (idx_q == IDX_W'(PAT_WORDS - 1));
  assign mism      = in_check && (in_data != pat_words[idx_q]);
  assign hunt_hit  = in_hunt && (in_data == pat_words[0]);
  assign hunt_miss = in_hunt && !hunt_hit;
  assign hunt_to   = hunt_miss && ((hunt_cnt + REP_W'(1)) == REP_W'(HUNT_MAX));

  // A repetition that ends on an aborting mismatch is partial and never counts.
  assign err_en   = mism;
  assign rep_en   = in_check && last_word && !(STOP_ON_ERR && mism);
  assign rep_done = rep_en && ((rep_cnt + REP_W'(1)) == n_q);

  pd_sat_counter #(.W(REP_W)) u_err_cnt (
    .clk     (clk),
    .rst_n   (rst),
    .clr_i   (start_acc),
    .en_i    (err_en),
    .count_o (err_cnt)
  );

  pd_sat_counter #(.W(REP_W)) u_rep_cnt (
    .clk     (clk),
    .rst_n   (rst),
    .clr_i   (start_acc),
    .en_i    (rep_en),
    .count_o (rep_cnt)
  );

  pd_sat_counter #(.W(REP_W)) u_hunt_cnt (
    .clk     (clk),
    .rst_n   (rst),
    .clr_i   (start_acc),
    .en_i    (hunt_miss),
    .count_o (hunt_cnt)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    flag_d    = flag_q;
    timeout_d = timeout_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          idx_d     = '0;
          flag_d    = 1'b0;
          timeout_d = 1'b0;
          if (n_detec == '0) begin
            state_d = ST_DONE;
          end else if (SYNC_HUNT) begin
            state_d = ST_HUNT;
          end else begin
            state_d = ST_CHECK;
          end
        end
      end
      ST_HUNT: begin
        if (hunt_hit) begin
          state_d = ST_CHECK;
          idx_d   = IDX_W'(1);
        end else if (hunt_to) begin
          state_d   = ST_DONE;
          timeout_d = 1'b1;
        end
      end
      ST_CHECK: begin
        if (in_valid) begin
          idx_d = last_word ? '0 : idx_q + IDX_W'(1);
          if (rep_done) begin
            state_d = ST_DONE;
            // Counters update on this same edge, so judge the pass from pre-edge count plus this beat.
            flag_d  = !mism && (err_cnt == '0);
          end else if (STOP_ON_ERR && mism) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      n_q       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      flag_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      busy_q    <= (state_d != ST_IDLE);
      done_q    <= (state_d == ST_DONE);
      flag_q    <= flag_d;
      timeout_q <= timeout_d;
      if (start_acc) begin
        n_q <= n_detec;
      end
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign pattern_flag = flag_q;
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_pattern_detector_gen.sv
// Drives three detector configurations (stop, count, hunt) from one stimulus stream
// and compares every output each cycle against a beat-level reference model.
module tb_pattern_detector_gen;

  localparam int ND = 3;
  localparam int PW = 4;

  localparam bit CFG_HUNT [ND] = '{1'b0, 1'b0, 1'b1};
  localparam bit CFG_STOP [ND] = '{1'b1, 1'b0, 1'b1};
  localparam int CFG_HMAX [ND] = '{255, 255, 4};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] n_detec = '0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;

  logic       busy_w [ND];
  logic       done_w [ND];
  logic       flag_w [ND];
  logic       tout_w [ND];
  logic [7:0] err_w  [ND];
  logic [7:0] rep_w  [ND];

  logic [7:0] pat [PW] = '{8'hAB, 8'hCD, 8'hEF, 8'h23};

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pattern_detector_gen #(.STOP_ON_ERR(1'b1), .SYNC_HUNT(1'b0)) u_stop (
    .clk(clk), .rst(rst), .start(start), .n_detec(n_detec), .in_valid(in_valid),
    .in_data(in_data), .busy(busy_w[0]), .done(done_w[0]), .pattern_flag(flag_w[0]),
    .timeout(tout_w[0]), .err_cnt(err_w[0]), .rep_cnt(rep_w[0]));

  pattern_detector_gen #(.STOP_ON_ERR(1'b0), .SYNC_HUNT(1'b0)) u_cnt (
    .clk(clk), .rst(rst), .start(start), .n_detec(n_detec), .in_valid(in_valid),
    .in_data(in_data), .busy(busy_w[1]), .done(done_w[1]), .pattern_flag(flag_w[1]),
    .timeout(tout_w[1]), .err_cnt(err_w[1]), .rep_cnt(rep_w[1]));

  pattern_detector_gen #(.STOP_ON_ERR(1'b1), .SYNC_HUNT(1'b1), .HUNT_MAX(4)) u_hunt (
    .clk(clk), .rst(rst), .start(start), .n_detec(n_detec), .in_valid(in_valid),
    .in_data(in_data), .busy(busy_w[2]), .done(done_w[2]), .pattern_flag(flag_w[2]),
    .timeout(tout_w[2]), .err_cnt(err_w[2]), .rep_cnt(rep_w[2]));

  // Reference model: tracks how many pattern beats have been consumed, not FSM states.
  typedef struct {
    bit busy;
    bit done;
    bit flag;
    bit tout;
    bit hunting;
    int pos;
    int errs;
    int hunt_n;
    int n;
  } model_t;

  model_t mdl [ND];

  function automatic model_t step(input model_t m_in, input int k);
    model_t m = m_in;
    bit bad;
    if (m.done) begin
      m.done = 1'b0;
      m.busy = 1'b0;
    end else if (!m.busy) begin
      if (start) begin
        m.busy    = 1'b1;
        m.n       = int'(n_detec);
        m.pos     = 0;
        m.errs    = 0;
        m.hunt_n  = 0;
        m.flag    = 1'b0;
        m.tout    = 1'b0;
        m.hunting = CFG_HUNT[k];
        m.done    = (n_detec == 8'd0);
      end
    end else if (in_valid) begin
      if (m.hunting) begin
        if (in_data == pat[0]) begin
          m.hunting = 1'b0;
          m.pos     = 1;
        end else begin
          m.hunt_n++;
          if (m.hunt_n == CFG_HMAX[k]) begin
            m.tout = 1'b1;
            m.done = 1'b1;
          end
        end
      end else begin
        bad = (in_data != pat[m.pos % PW]);
        if (bad) m.errs++;
        if (bad && CFG_STOP[k]) begin
          m.done = 1'b1;
        end else begin
          m.pos++;
          if (m.pos == PW * m.n) begin
            m.done = 1'b1;
            m.flag = (m.errs == 0);
          end
        end
      end
    end
    return m;
  endfunction

  always @(posedge clk or negedge rst) begin
    for (int i = 0; i < ND; i++) begin
      if (!rst) mdl[i] <= '{default: 0};
      else      mdl[i] <= step(mdl[i], i);
    end
  end

  function automatic string nm(input int i);
    case (i)
      0:       return "stop";
      1:       return "cnt";
      default: return "hunt";
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < ND; i++) begin
      check({nm(i), ".busy"},    32'(busy_w[i]), 32'(mdl[i].busy));
      check({nm(i), ".done"},    32'(done_w[i]), 32'(mdl[i].done));
      check({nm(i), ".flag"},    32'(flag_w[i]), 32'(mdl[i].flag));
      check({nm(i), ".timeout"}, 32'(tout_w[i]), 32'(mdl[i].tout));
      check({nm(i), ".err_cnt"}, 32'(err_w[i]),  32'((mdl[i].errs > 255) ? 255 : mdl[i].errs));
      check({nm(i), ".rep_cnt"}, 32'(rep_w[i]),  32'(mdl[i].pos / PW));
    end
  end

  task automatic cyc(input logic s, input logic [7:0] n, input logic v, input logic [7:0] d);
    start    = s;
    n_detec  = n;
    in_valid = v;
    in_data  = d;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [31:0] w);
    logic [31:0] t;
    t = w;
    for (int b = 0; b < 4; b++) begin
      cyc(1'b0, 8'd0, 1'b1, t[31:24]);
      t = t << 8;
    end
  endtask

  task automatic do_reset();
    start    = 1'b0;
    in_valid = 1'b0;
    rst      = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst.busy", 32'(busy_w[0]), 0);
    check("rst.done", 32'(done_w[0]), 0);
    check("rst.flag", 32'(flag_w[0]), 0);
    check("rst.err",  32'(err_w[0]),  0);
    check("rst.rep",  32'(rep_w[0]),  0);

    // Clean run, three repetitions
    cyc(1'b1, 8'd3, 1'b0, 8'h00);
    check("clean.busy_t1", 32'(busy_w[0]), 1);
    repeat (3) send(32'hABCDEF23);
    check("clean.done", 32'(done_w[0]), 1);
    check("clean.flag", 32'(flag_w[0]), 1);
    check("clean.rep",  32'(rep_w[0]),  3);
    check("clean.err",  32'(err_w[0]),  0);
    cyc(1'b0, 8'd0, 1'b0, 8'h00);
    check("clean.busy_l2", 32'(busy_w[0]), 0);

    // Stop on first mismatch
    do_reset();
    cyc(1'b1, 8'd2, 1'b0, 8'h00);
    send(32'hABCDEF23);
    cyc(1'b0, 8'd0, 1'b1, 8'hAB);
    cyc(1'b0, 8'd0, 1'b1, 8'h00);
    check("stop.done", 32'(done_w[0]), 1);
    check("stop.flag", 32'(flag_w[0]), 0);
    check("stop.err",  32'(err_w[0]),  1);
    check("stop.rep",  32'(rep_w[0]),  1);

    // Count mode, second repetition's EF and 23 corrupted
    do_reset();
    cyc(1'b1, 8'd2, 1'b0, 8'h00);
    send(32'hABCDEF23);
    send(32'hABCD0000);
    check("count.done", 32'(done_w[1]), 1);
    check("count.err",  32'(err_w[1]),  2);
    check("count.rep",  32'(rep_w[1]),  2);
    check("count.flag", 32'(flag_w[1]), 0);

    // Stalls with garbage on invalid beats
    do_reset();
    cyc(1'b1, 8'd1, 1'b0, 8'h00);
    cyc(1'b0, 8'd0, 1'b0, 8'h55);
    cyc(1'b0, 8'd0, 1'b1, 8'hAB);
    cyc(1'b0, 8'd0, 1'b0, 8'hAB);
    cyc(1'b0, 8'd0, 1'b0, 8'h77);
    cyc(1'b0, 8'd0, 1'b1, 8'hCD);
    cyc(1'b0, 8'd0, 1'b1, 8'hEF);
    cyc(1'b0, 8'd0, 1'b0, 8'h00);
    cyc(1'b0, 8'd0, 1'b0, 8'h23);
    check("stall.done_early", 32'(done_w[0]), 0);
    cyc(1'b0, 8'd0, 1'b1, 8'h23);
    check("stall.done", 32'(done_w[0]), 1);
    check("stall.flag", 32'(flag_w[0]), 1);
    check("stall.rep",  32'(rep_w[0]),  1);

    // Sync hunt finds the pattern after two junk beats
    do_reset();
    cyc(1'b1, 8'd1, 1'b0, 8'h00);
    cyc(1'b0, 8'd0, 1'b1, 8'h11);
    cyc(1'b0, 8'd0, 1'b1, 8'h22);
    send(32'hABCDEF23);
    check("hunt.done", 32'(done_w[2]), 1);
    check("hunt.flag", 32'(flag_w[2]), 1);
    check("hunt.tout", 32'(tout_w[2]), 0);
    check("hunt.rep",  32'(rep_w[2]),  1);

    // Sync hunt times out after HUNT_MAX discards
    do_reset();
    cyc(1'b1, 8'd1, 1'b0, 8'h00);
    cyc(1'b0, 8'd0, 1'b1, 8'h11);
    cyc(1'b0, 8'd0, 1'b1, 8'h22);
    cyc(1'b0, 8'd0, 1'b1, 8'h33);
    cyc(1'b0, 8'd0, 1'b1, 8'h44);
    check("hto.done", 32'(done_w[2]), 1);
    check("hto.tout", 32'(tout_w[2]), 1);
    check("hto.flag", 32'(flag_w[2]), 0);
    cyc(1'b0, 8'd0, 1'b1, 8'h55);
    check("hto.busy", 32'(busy_w[2]), 0);
    check("hto.tout_held", 32'(tout_w[2]), 1);

    // n_detec == 0 finishes at T+1 without a pass
    do_reset();
    cyc(1'b1, 8'd0, 1'b0, 8'h00);
    check("zero.done", 32'(done_w[0]), 1);
    check("zero.busy", 32'(busy_w[0]), 1);
    check("zero.flag", 32'(flag_w[0]), 0);
    cyc(1'b0, 8'd0, 1'b0, 8'h00);
    check("zero.done_off", 32'(done_w[0]), 0);

    // Start while busy keeps the original repetition count
    do_reset();
    cyc(1'b1, 8'd2, 1'b0, 8'h00);
    cyc(1'b0, 8'd0, 1'b1, 8'hAB);
    cyc(1'b1, 8'd1, 1'b1, 8'hCD);
    cyc(1'b0, 8'd0, 1'b1, 8'hEF);
    cyc(1'b0, 8'd0, 1'b1, 8'h23);
    check("busy_start.done_mid", 32'(done_w[0]), 0);
    check("busy_start.rep_mid",  32'(rep_w[0]),  1);
    send(32'hABCDEF23);
    check("busy_start.done", 32'(done_w[0]), 1);
    check("busy_start.rep",  32'(rep_w[0]),  2);
    check("busy_start.flag", 32'(flag_w[0]), 1);

    // Reset mid-check, then a fresh run
    do_reset();
    cyc(1'b1, 8'd2, 1'b0, 8'h00);
    cyc(1'b0, 8'd0, 1'b1, 8'hAB);
    cyc(1'b0, 8'd0, 1'b1, 8'hCD);
    #2 rst = 1'b0;
    #1;
    check("midrst.busy", 32'(busy_w[0]), 0);
    check("midrst.done", 32'(done_w[0]), 0);
    check("midrst.rep",  32'(rep_w[0]),  0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    cyc(1'b1, 8'd1, 1'b0, 8'h00);
    send(32'hABCDEF23);
    check("midrst.rerun_flag", 32'(flag_w[0]), 1);

    // Start on the done cycle is ignored; the next cycle is accepted
    cyc(1'b1, 8'd1, 1'b0, 8'h00);
    check("b2b.ignored", 32'(busy_w[0]), 0);
    cyc(1'b1, 8'd1, 1'b0, 8'h00);
    check("b2b.accepted", 32'(busy_w[0]), 1);
    check("b2b.flag_cleared", 32'(flag_w[0]), 0);
    send(32'hABCDEF23);
    check("b2b.done", 32'(done_w[0]), 1);
    check("b2b.flag", 32'(flag_w[0]), 1);

    // Error counter saturates in count mode
    do_reset();
    cyc(1'b1, 8'd70, 1'b0, 8'h00);
    repeat (280) cyc(1'b0, 8'd0, 1'b1, 8'h00);
    check("sat.done", 32'(done_w[1]), 1);
    check("sat.err",  32'(err_w[1]),  255);
    check("sat.rep",  32'(rep_w[1]),  70);
    check("sat.flag", 32'(flag_w[1]), 0);

    repeat (2) cyc(1'b0, 8'd0, 1'b0, 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pattern_detector_gen.md
# pattern_detector_gen

Parametrised successor to the fixed 4-byte PRBS pattern detector. It checks a streaming PRBS/data bus against a compile-time pattern of PAT_WORDS words, repeated a run-time number of times. It adds valid-qualified input with stalls, an optional sync-hunt with timeout, a stop-on-error or count-errors mode, and registered status and error counters. It sits after the PRBS generator/lane mux in the test datapath and reports pass/fail to the control block.

## Interface
Parameters:
- DATA_W, 8, width of one stream word
- PAT_WORDS, 4, number of words in the pattern (2..16)
- PATTERN, 32'hABCDEF23, pattern of DATA_W*PAT_WORDS bits; the MS word is compared first
- REP_W, 8, width of the repetition count and counters
- STOP_ON_ERR, 1, 1 = abort at first mismatch; 0 = run all repetitions and count errors
- SYNC_HUNT, 0, 1 = discard beats until the first pattern word is seen
- HUNT_MAX, 255, maximum beats discarded in hunt before timeout

Ports:
- clk, input, 1, single clock, rising edge
- rst, input, 1, asynchronous, active-low reset
- start, input, 1, one-cycle pulse that launches a check; ignored while busy
- n_detec, input, REP_W, repetitions to check; sampled on start
- in_valid, input, 1, qualifies in_data
- in_data, input, DATA_W, stream word
- busy, output, 1, high from the cycle after start through DONE
- done, output, 1, one-cycle pulse at end of check
- pattern_flag, output, 1, 1 = pass; held until the next accepted start
- timeout, output, 1, hunt expired; held until the next accepted start
- err_cnt, output, REP_W, mismatched words, saturating
- rep_cnt, output, REP_W, repetitions fully compared

## Operation
- States:
  - IDLE: on start, capture n_detec, clear flag, timeout and counters, then go to HUNT if SYNC_HUNT else CHECK.
  - If n_detec==0, go straight to DONE with pattern_flag=0.
- HUNT:
  - Each valid beat whose word equals the first pattern word counts as word 0. It is compared, and the FSM moves to CHECK with word index 1.
  - Otherwise the hunt counter is incremented.
  - When the hunt counter reaches HUNT_MAX, set timeout=1 and go to DONE with pattern_flag=0.
- CHECK:
  - Each valid beat is compared against pattern word[idx].
  - idx wraps from PAT_WORDS-1 to 0 and increments rep_cnt.
  - When rep_cnt reaches the captured n_detec, go to DONE.
- Mismatch handling:
  - On a mismatch, err_cnt increments, saturating at 2^REP_W-1.
  - If STOP_ON_ERR, the mismatching beat ends the check and the FSM goes to DONE. rep_cnt is not incremented for the partial repetition.
- DONE:
  - done=1 for one cycle.
  - pattern_flag = (err_cnt==0 && !timeout && n_detec!=0).
  - Then go to IDLE.
- in_valid=0 freezes idx, counters and hunt counter, in every state.
- Beats arriving in IDLE or DONE are ignored.
- A start pulse while busy is ignored and does not restart the check.
- Pattern words are sliced from PATTERN as PATTERN[DATA_W*(PAT_WORDS-idx)-1 -: DATA_W].

## Timing
- Reset (rst low, asynchronous) forces IDLE. busy, done, pattern_flag, timeout, err_cnt and rep_cnt are all 0.
- Reset asserted mid-check abandons the check; no done pulse is issued.
- All outputs are registered.
- start at cycle T gives busy=1 at T+1. The first beat can be accepted at T+1.
- The last compared beat at cycle L gives DONE state and done=1 at L+1, with pattern_flag and counters valid at L+1 and held afterwards. busy drops at L+2.
- With no stalls and no sync-hunt, a pass takes PAT_WORDS*n_detec beats plus 1 cycle to done.
- With n_detec==0, done is asserted at T+1.
- A start in the same cycle as done is ignored. The earliest new start is the cycle after done.

## Structure
- pattern_detector_pkg holds:
  - the state enum (IDLE, HUNT, CHECK, DONE)
  - the default PATTERN constant
  - a word-select function for PATTERN
- One sub-module, pd_sat_counter: a REP_W saturating counter with enable and clear, used for err_cnt, rep_cnt and the hunt counter.

## Test plan
- Clean run: n_detec=3, stream AB CD EF 23 ×3 with in_valid always high -> done at beat 12 + 1 cycle, pattern_flag=1, rep_cnt=3, err_cnt=0.
- Mismatch with STOP_ON_ERR=1: n_detec=2, stream AB CD EF 23 AB 00 -> done the cycle after 00, pattern_flag=0, err_cnt=1, rep_cnt=1.
- Count mode with STOP_ON_ERR=0: n_detec=2, with the second repetition's EF and 23 corrupted -> done after beat 8, err_cnt=2, rep_cnt=2, pattern_flag=0.
- Stalls: in_valid toggled randomly in a clean n_detec=1 run -> the same result as the clean run; done occurs one cycle after the 4th valid beat.
- Sync-hunt with SYNC_HUNT=1, HUNT_MAX=4:
  - Stream 11 22 AB CD EF 23 -> pass.
  - Stream 11 22 33 44 55 -> timeout=1, pattern_flag=0.
- Boundaries:
  - n_detec=0 -> done at T+1 with flag=0.
  - start while busy -> ignored.
  - rst pulsed mid-check -> all outputs 0, no done; a fresh run then passes.
